shop_pipe_v: RTL and testbench

//  Pipelined, width-parametrised successor of the 3-input selectable gate unit.

---
 rtl/shop_pipe_v_if.sv | 31 +++
 rtl/shop_pipe_v.sv | 118 +++++++++++
 tb/tb_shop_pipe_v.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shop_pipe_v_if.sv
// Operand-source / result-sink handshake bundle for shop_pipe_v.
// slave = the unit itself, master = the side driving operands and taking results.
interface shop_pipe_v_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_c;
    logic [2:0]       i_code;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_f;
    logic [2:0]       o_code;
    logic             o_err;
    logic [CW-1:0]    o_count;

    modport slave (
        input  i_valid, i_a, i_b, i_c, i_code, i_ready,
        output o_ready, o_valid, o_f, o_code, o_err, o_count
    );

    modport master (
        output i_valid, i_a, i_b, i_c, i_code, i_ready,
        input  o_ready, o_valid, o_f, o_code, o_err, o_count
    );
endinterface

// File: rtl/shop_pipe_v.sv
// Pipelined 3-operand bitwise function unit with output FIFO; SHOP_EXT_OPS_EN enables codes 4-7.
// Latency: 2 cycles from accept to o_valid when the FIFO is empty.
// Backpressure: o_ready comes only from registered occupancy (FIFO + stage 1), never from i_ready.
module shop_pipe_v #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    shop_pipe_v_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic [2:0]       code;
        logic             err;
    } entry_t;

    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_c;
    logic [2:0]       r_s1_code;

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    entry_t           w_push_e;
    entry_t           w_head_e;
    logic [CW:0]      w_occ;
    logic             w_ready;
    logic             w_accept;
    logic             w_empty;
    logic             w_pop;

    // Stage 1 counts as occupied so it can always drain into the FIFO next edge.
    assign w_occ    = {1'b0, r_count} + {{CW{1'b0}}, r_s1_vld};
    assign w_ready  = (w_occ < (CW+1)'(DEPTH));
    assign w_accept = bus.i_valid && w_ready;
    assign w_empty  = (r_count == '0);
    assign w_pop    = bus.i_ready && !w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_c    <= '0;
            r_s1_code <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_a    <= bus.i_a;
                r_s1_b    <= bus.i_b;
                r_s1_c    <= bus.i_c;
                r_s1_code <= bus.i_code;
            end
        end
    end

    always_comb begin
        w_push_e      = '0;
        w_push_e.code = r_s1_code;
        case (r_s1_code)
            3'd0: w_push_e.f = r_s1_a ^ r_s1_b ^ r_s1_c;
            3'd1: w_push_e.f = ~(r_s1_a & r_s1_b & r_s1_c);
            3'd2: w_push_e.f = ~(r_s1_a | r_s1_b | r_s1_c);
            3'd3: w_push_e.f = ~(r_s1_a ^ r_s1_b ^ r_s1_c);
`ifdef SHOP_EXT_OPS_EN
            3'd4: w_push_e.f = r_s1_a & r_s1_b & r_s1_c;
            3'd5: w_push_e.f = r_s1_a | r_s1_b | r_s1_c;
            3'd6: w_push_e.f = (r_s1_a & r_s1_b) | (r_s1_a & r_s1_c) | (r_s1_b & r_s1_c);
            3'd7: w_push_e.f = r_s1_a;
`else
            default: w_push_e.err = 1'b1;
`endif
        endcase
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (r_s1_vld) begin
            r_mem[r_wr_ptr] <= w_push_e;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_s1_vld) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({r_s1_vld, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_e    = r_mem[r_rd_ptr];
    assign bus.o_ready = w_ready;
    assign bus.o_count = r_count;
    assign bus.o_valid = !w_empty;
    assign bus.o_f     = w_empty ? '0 : w_head_e.f;
    assign bus.o_code  = w_empty ? '0 : w_head_e.code;
    assign bus.o_err   = w_empty ? 1'b0 : w_head_e.err;
endmodule

// File: tb/tb_shop_pipe_v.sv
module tb_shop_pipe_v;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    shop_pipe_v_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    shop_pipe_v #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] f;
        logic [2:0] code;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [2:0] code;
        logic [7:0] f_ext;
        logic       err_ext;
        logic [7:0] f_base;
        logic       err_base;
    } vec_t;

    // a, b, c, code, result with extended ops, err, result without, err
    vec_t vecs [12] = '{
        '{8'hF0, 8'hCC, 8'hAA, 3'd0, 8'h96, 1'b0, 8'h96, 1'b0},
        '{8'hF0, 8'hCC, 8'hAA, 3'd1, 8'h7F, 1'b0, 8'h7F, 1'b0},
        '{8'hF0, 8'hCC, 8'hAA, 3'd2, 8'h01, 1'b0, 8'h01, 1'b0},
        '{8'hF0, 8'hCC, 8'hAA, 3'd3, 8'h69, 1'b0, 8'h69, 1'b0},
        '{8'h0F, 8'h33, 8'h55, 3'd6, 8'h17, 1'b0, 8'h00, 1'b1},
        '{8'hF0, 8'hCC, 8'hAA, 3'd4, 8'h80, 1'b0, 8'h00, 1'b1},
        '{8'hF0, 8'hCC, 8'hAA, 3'd5, 8'hFE, 1'b0, 8'h00, 1'b1},
        '{8'hF0, 8'hCC, 8'hAA, 3'd7, 8'hF0, 1'b0, 8'h00, 1'b1},
        '{8'h00, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0},
        '{8'hFF, 8'hFF, 8'hFF, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0},
        '{8'h00, 8'h00, 8'h00, 3'd2, 8'hFF, 1'b0, 8'hFF, 1'b0},
        '{8'h12, 8'h34, 8'h56, 3'd3, 8'h8F, 1'b0, 8'h8F, 1'b0}
    };

    exp_t q [$];
    exp_t cur_exp;
    int   inflight = 0;
    int   s1m      = 0;
    int   n_acc    = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t vec_exp(input vec_t v);
        exp_t e;
`ifdef SHOP_EXT_OPS_EN
        e = '{v.f_ext, v.code, v.err_ext};
`else
        e = '{v.f_base, v.code, v.err_base};
`endif
        return e;
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c, input logic [2:0] code);
        exp_t e;
        e = '{8'h00, code, 1'b0};
        if (code == 3'd0)      e.f = a ^ b ^ c;
        else if (code == 3'd1) e.f = ~(a & b & c);
        else if (code == 3'd2) e.f = ~(a | b | c);
        else if (code == 3'd3) e.f = ~(a ^ b ^ c);
`ifdef SHOP_EXT_OPS_EN
        else if (code == 3'd4) e.f = a & b & c;
        else if (code == 3'd5) e.f = a | b | c;
        else if (code == 3'd6) e.f = (a & b) | (b & c) | (a & c);
        else                   e.f = a;
`else
        else                   e.err = 1'b1;
`endif
        return e;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        inflight = 0;
        s1m      = 0;
    end

    // Monitor: occupancy model, handshake observation and in-order scoreboard.
    always @(negedge clk) begin
        int   exp_cnt;
        logic pop;
        logic acc;
        exp_t e;
        if (rst_n) begin
            exp_cnt = inflight - s1m;
            chk("o_ready", 32'(bus.o_ready), 32'(inflight < DEPTH));
            chk("o_count", 32'(bus.o_count), exp_cnt);
            chk("o_valid", 32'(bus.o_valid), 32'(exp_cnt != 0));
            if (!bus.o_valid) begin
                chk("idle_o_f", 32'(bus.o_f), 0);
                chk("idle_o_code", 32'(bus.o_code), 0);
                chk("idle_o_err", 32'(bus.o_err), 0);
            end
            pop = bus.o_valid && bus.i_ready;
            if (pop) begin
                if (q.size() == 0) begin
                    chk("spurious_pop", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("o_f", 32'(bus.o_f), 32'(e.f));
                    chk("o_code", 32'(bus.o_code), 32'(e.code));
                    chk("o_err", 32'(bus.o_err), 32'(e.err));
                end
            end
            acc = bus.i_valid && (inflight < DEPTH);
            if (acc) begin
                q.push_back(cur_exp);
                n_acc++;
            end
            inflight = inflight + int'(acc) - int'(pop);
            s1m      = int'(acc);
        end
    end

    task automatic present(input int i);
        bus.i_a    = vecs[i].a;
        bus.i_b    = vecs[i].b;
        bus.i_c    = vecs[i].c;
        bus.i_code = vecs[i].code;
        cur_exp    = vec_exp(vecs[i]);
        bus.i_valid = 1'b1;
    endtask

    task automatic wait_acc(input int start);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (n_acc != start) break;
        end
        if (n_acc == start) chk("accept_timeout", 0, 1);
        bus.i_valid = 1'b0;
    endtask

    task automatic send_vec(input int i);
        int start;
        start = n_acc;
        present(i);
        wait_acc(start);
    endtask

    task automatic drain(input int bound);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 0; k < bound; k++) begin
            if (inflight == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", inflight, 0);
    endtask

    initial begin
        int start;
        int t0;
        int last;
        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_c     = '0;
        bus.i_code  = '0;
        bus.i_ready = 1'b0;
        cur_exp     = '0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(bus.o_valid), 0);
        chk("rst_o_ready", 32'(bus.o_ready), 1);
        chk("rst_o_count", 32'(bus.o_count), 0);
        chk("rst_o_f", 32'(bus.o_f), 0);
        chk("rst_o_code", 32'(bus.o_code), 0);
        chk("rst_o_err", 32'(bus.o_err), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Base functions back-to-back with a free-running sink.
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_vec(i);
        drain(20);

        // Two-cycle latency into an empty FIFO.
        send_vec(8);
        chk("lat_edge_n", 32'(bus.o_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_edge_n1", 32'(bus.o_valid), 1);
        chk("lat_o_f", 32'(bus.o_f), 32'h00);
        drain(20);

        // Extended / unsupported opcodes and operand corners.
        for (int i = 4; i < 12; i++) send_vec(i);
        drain(20);

        // Fill with a stalled sink: exactly DEPTH accepted.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(i);
        chk("fill_ready_s1", 32'(bus.o_ready), 0);
        chk("fill_cnt3_s1", 32'(bus.o_count), 3);
        start = n_acc;
        present(5);
        repeat (4) @(posedge clk);
        #1;
        chk("full_count", 32'(bus.o_count), 4);
        chk("full_ready", 32'(bus.o_ready), 0);
        chk("held_not_acc", n_acc, start);
        bus.i_ready = 1'b1;
        wait_acc(start);
        drain(20);
        chk("ready_after_drain", 32'(bus.o_ready), 1);

        // Refill, then stream 20 transactions with push and pop every cycle.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(i);
        bus.i_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 20; k++) send_vec(k % 12);
        chk("stream_cycles_ok", 32'((cyc - t0) <= 24), 1);
        drain(20);

        // Reset with three buffered entries and stage 1 occupied.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(i);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(bus.o_valid), 0);
        chk("midrst_o_count", 32'(bus.o_count), 0);
        chk("midrst_o_f", 32'(bus.o_f), 0);
        chk("midrst_o_ready", 32'(bus.o_ready), 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        send_vec(11);
        drain(20);

        // Random operands, opcodes and handshakes on both sides.
        last = n_acc;
        for (int k = 0; k < 400; k++) begin
            if (!bus.i_valid || n_acc != last) begin
                last = n_acc;
                if ($urandom_range(0, 3) != 0) begin
                    bus.i_a     = 8'($urandom);
                    bus.i_b     = 8'($urandom);
                    bus.i_c     = 8'($urandom);
                    bus.i_code  = 3'($urandom_range(0, 7));
                    cur_exp     = model(bus.i_a, bus.i_b, bus.i_c, bus.i_code);
                    bus.i_valid = 1'b1;
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
            bus.i_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        drain(60);
        chk("scoreboard_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
